multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (asserted at 0).
REQ-003 SHALL have ports: instruction  in  32  current IR contents; op=[31:26], funct=[5:0].
REQ-004 SHALL have ports: zero  in  1  ALU zero flag from datapath.
REQ-005 SHALL have ports: memReady  in  1  memory completion handshake.
REQ-006 SHALL have ports: memRead, memWrite, iOrD, irWrite, pcWrite, pcEn, regWrite, regDst, memToReg, branch, jump, aluSrcA  out  1  datapath controls.
REQ-007 SHALL have ports: aluSrcB  out  2  (00 regB, 01 const 4, 10 signImm, 11 signImm<<2); pcSrc  out  2  (00 ALU result, 01 aluOut reg, 10 jump target).
REQ-008 SHALL have ports: aluControl  out  4  (0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR); illegal  out  1; state  out  4  debug.

Function
REQ-009 SHALL implement Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; outputs default 0 unless listed.
REQ-010 FETCH SHALL drive memRead=1, iOrD=0, aluSrcA=0, aluSrcB=01, aluControl=ADD, pcSrc=00; irWrite=pcWrite=1 only in cycle memReady=1, then go to DECODE; else hold FETCH.
REQ-011 DECODE SHALL drive aluSrcA=0, aluSrcB=11, ADD; next by op: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEX, 000010 -> JUMP.
REQ-012 Unknown op, or op=000000 with funct outside {100000 add,100010 sub,100100 and,100101 or,100111 nor,101010 slt}, SHALL assert illegal=1 for that DECODE cycle only and return to FETCH.
REQ-013 MEMADR SHALL drive aluSrcA=1, aluSrcB=10, ADD; next MEMRD for lw, MEMWR for sw.
REQ-014 MEMRD SHALL drive memRead=1, iOrD=1; hold until memReady=1, then MEMWB.
REQ-015 MEMWB SHALL drive regWrite=1, memToReg=1, regDst=0; next FETCH.
REQ-016 MEMWR SHALL drive memWrite=1, iOrD=1; hold until memReady=1, then FETCH.
REQ-017 EXECUTE SHALL drive aluSrcA=1, aluSrcB=00, aluControl from funct; next ALUWB (regWrite=1, regDst=1, memToReg=0), then FETCH.
REQ-018 BRANCH SHALL drive aluSrcA=1, aluSrcB=00, SUB, branch=1, pcSrc=01; next FETCH.
REQ-019 ADDIEX SHALL drive aluSrcA=1, aluSrcB=10, ADD; ADDIWB SHALL drive regWrite=1, regDst=0; then FETCH.
REQ-020 JUMP SHALL drive jump=1, pcWrite=1, pcSrc=10; next FETCH.
REQ-021 pcEn SHALL equal pcWrite | (branch & zero), combinational.
REQ-022 With memReady tied 1, latency SHALL be lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles.
REQ-023 memReady SHALL be ignored outside FETCH, MEMRD, MEMWR.

Reset
REQ-024 reset=0 SHALL force state=FETCH asynchronously and all outputs to 0 (including memRead) while asserted.
REQ-025 Reset mid-instruction (incl. wait states) SHALL abandon it; no write strobe after reset asserts.
REQ-026 After reset release, first rising edge SHALL see FETCH outputs per REQ-010.

Structure
REQ-027 Package controller_pkg SHALL hold state enum, opcode/funct constants, aluControl encodings, aluSrcB/pcSrc encodings.
REQ-028 Sub-module alu_decoder SHALL map (aluOp, funct) to aluControl and funct-valid, combinational.

Verification
REQ-029 lw 32'h8C080004, memReady=1 -> states 0,1,2,3,4; regWrite=memToReg=1 only in cycle 5.
REQ-030 add 32'h01095020 -> EXECUTE aluControl=0010, ALUWB regDst=1 regWrite=1; back to FETCH after 4 cycles.
REQ-031 beq 32'h11090002: zero=1 in BRANCH -> pcEn=1; zero=0 -> pcEn=0; 3 cycles.
REQ-032 FETCH with memReady=0 for 3 cycles -> state=0, memRead=1, irWrite=pcWrite=0; 4th cycle memReady=1 -> irWrite=pcWrite=1.
REQ-033 instruction 32'hFC000000 -> illegal=1 one cycle in DECODE, then state=0, no regWrite/memWrite.
REQ-034 reset=0 during MEMWR with memReady=0 -> memWrite=0 immediately, state=0.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared definitions for the multicycle MIPS-style controller.
// Holds the FSM state encoding (the numeric values are visible on the
// debug 'state' port), opcode/funct constants, the aluControl encodings,
// the aluSrcB/pcSrc mux selects, and the control-strobe bundle.
package controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_e;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // aluControl encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ALU operation request from the FSM to the ALU decoder.
    // ALUOP_NONE yields aluControl=0000 for states that do not use the ALU.
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_NONE  = 2'b11
    } alu_op_e;

    // aluSrcB selects
    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pcSrc selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Datapath control strobes produced per state.
    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the FSM's ALU request and the instruction funct field
// to the 4-bit aluControl code. Purely combinational.
// Ports:
//   i_alu_op       ALU request (ADD, SUB, from funct, none)
//   i_funct        instruction[5:0]
//   o_alu_control  aluControl code for the datapath ALU
//   o_funct_valid  1 when i_funct is one of the supported R-type functs
module alu_decoder
    import controller_pkg::*;
(
    input  alu_op_e     i_alu_op,
    input  logic [5:0]  i_funct,
    output logic [3:0]  o_alu_control,
    output logic        o_funct_valid
);

    logic [3:0] w_funct_ctrl;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statements can leave it unassigned (no latch).
    always_comb begin
        w_funct_ctrl  = ALU_AND;
        o_funct_valid = 1'b1;
        case (i_funct)
            FUNCT_ADD: w_funct_ctrl = ALU_ADD;
            FUNCT_SUB: w_funct_ctrl = ALU_SUB;
            FUNCT_AND: w_funct_ctrl = ALU_AND;
            FUNCT_OR:  w_funct_ctrl = ALU_OR;
            FUNCT_NOR: w_funct_ctrl = ALU_NOR;
            FUNCT_SLT: w_funct_ctrl = ALU_SLT;
            default:   o_funct_valid = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_control = ALU_AND;
        case (i_alu_op)
            ALUOP_ADD:   o_alu_control = ALU_ADD;
            ALUOP_SUB:   o_alu_control = ALU_SUB;
            ALUOP_FUNCT: o_alu_control = w_funct_ctrl;
            ALUOP_NONE:  o_alu_control = ALU_AND;
            default:     o_alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle MIPS subset
// (lw, sw, R-type add/sub/and/or/nor/slt, beq, addi, j).
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-low; forces FETCH and zeroes outputs
//   instruction  current IR contents (op=[31:26], funct=[5:0])
//   zero         ALU zero flag, used only for pcEn during BRANCH
//   memReady     memory handshake, sampled in FETCH, MEMRD, MEMWR only
//   memRead..aluSrcA, aluSrcB, pcSrc, aluControl  datapath controls
//   pcEn         pcWrite | (branch & zero)
//   illegal      unsupported instruction seen in DECODE
//   state        current FSM state (debug)
module multicycle_controller
    import controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        memReady,
    output logic        memRead,
    output logic        memWrite,
    output logic        iOrD,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        pcEn,
    output logic        regWrite,
    output logic        regDst,
    output logic        memToReg,
    output logic        branch,
    output logic        jump,
    output logic        aluSrcA,
    output logic [1:0]  aluSrcB,
    output logic [1:0]  pcSrc,
    output logic [3:0]  aluControl,
    output logic        illegal,
    output logic [3:0]  state
);

    state_e      r_state;
    state_e      w_next_state;
    ctrl_t       w_ctrl;
    ctrl_t       w_ctrl_out;
    alu_op_e     w_alu_op;
    logic        w_illegal;
    logic [3:0]  w_alu_control;
    logic        w_funct_valid;
    logic [5:0]  w_op;
    logic [5:0]  w_funct;
    logic        w_unused_ir;

    assign w_op        = instruction[31:26];
    assign w_funct     = instruction[5:0];
    // Register/immediate fields are datapath business only.
    assign w_unused_ir = ^instruction[25:6];

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct       (w_funct),
        .o_alu_control (w_alu_control),
        .o_funct_valid (w_funct_valid)
    );

    // NOTE: state registers use non-blocking assignment so every flop
    // samples the pre-edge value, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ctrl       = '0;
        w_alu_op     = ALUOP_NONE;
        w_illegal    = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.pc_src    = PCSRC_ALU;
                w_alu_op         = ALUOP_ADD;
                // IR and PC load only in the cycle the memory completes.
                if (memReady) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_next_state    = S_DECODE;
                end
            end

            S_DECODE: begin
                w_ctrl.alu_src_b = SRCB_IMM_SH2;
                w_alu_op         = ALUOP_ADD;
                case (w_op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE: begin
                        if (w_funct_valid) begin
                            w_next_state = S_EXECUTE;
                        end else begin
                            w_illegal    = 1'b1;
                            w_next_state = S_FETCH;
                        end
                    end
                    OP_BEQ:  w_next_state = S_BRANCH;
                    OP_ADDI: w_next_state = S_ADDIEX;
                    OP_J:    w_next_state = S_JUMP;
                    default: begin
                        w_illegal    = 1'b1;
                        w_next_state = S_FETCH;
                    end
                endcase
            end

            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_alu_op         = ALUOP_ADD;
                w_next_state     = (w_op == OP_SW) ? S_MEMWR : S_MEMRD;
            end

            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.i_or_d   = 1'b1;
                if (memReady) begin
                    w_next_state = S_MEMWB;
                end
            end

            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_next_state      = S_FETCH;
            end

            S_MEMWR: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.i_or_d    = 1'b1;
                if (memReady) begin
                    w_next_state = S_FETCH;
                end
            end

            S_EXECUTE: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REGB;
                w_alu_op         = ALUOP_FUNCT;
                w_next_state     = S_ALUWB;
            end

            S_ALUWB: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
                w_next_state     = S_FETCH;
            end

            S_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_REGB;
                w_ctrl.branch    = 1'b1;
                w_ctrl.pc_src    = PCSRC_ALUOUT;
                w_alu_op         = ALUOP_SUB;
                w_next_state     = S_FETCH;
            end

            S_ADDIEX: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_alu_op         = ALUOP_ADD;
                w_next_state     = S_ADDIWB;
            end

            S_ADDIWB: begin
                w_ctrl.reg_write = 1'b1;
                w_next_state     = S_FETCH;
            end

            S_JUMP: begin
                w_ctrl.jump     = 1'b1;
                w_ctrl.pc_write = 1'b1;
                w_ctrl.pc_src   = PCSRC_JUMP;
                w_next_state    = S_FETCH;
            end

            default: w_next_state = S_FETCH;
        endcase
    end

    // Outputs are gated by reset combinationally: the state flop already
    // reads FETCH while reset is low, but FETCH itself drives memRead=1, so
    // without the gate a strobe would remain visible during reset.
    assign w_ctrl_out = reset ? w_ctrl : '0;

    assign memRead    = w_ctrl_out.mem_read;
    assign memWrite   = w_ctrl_out.mem_write;
    assign iOrD       = w_ctrl_out.i_or_d;
    assign irWrite    = w_ctrl_out.ir_write;
    assign pcWrite    = w_ctrl_out.pc_write;
    assign regWrite   = w_ctrl_out.reg_write;
    assign regDst     = w_ctrl_out.reg_dst;
    assign memToReg   = w_ctrl_out.mem_to_reg;
    assign branch     = w_ctrl_out.branch;
    assign jump       = w_ctrl_out.jump;
    assign aluSrcA    = w_ctrl_out.alu_src_a;
    assign aluSrcB    = w_ctrl_out.alu_src_b;
    assign pcSrc      = w_ctrl_out.pc_src;
    assign pcEn       = w_ctrl_out.pc_write | (w_ctrl_out.branch & zero);
    assign aluControl = reset ? w_alu_control : 4'b0000;
    assign illegal    = reset & w_illegal;
    assign state      = r_state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. A stimulus process expands
// each instruction into its sequence of controller phases (with random
// memory wait states), drives one phase per cycle and queues the expected
// output word; a monitor pops and compares at every falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction;
    logic        zero;
    logic        memReady;
    logic        memRead, memWrite, iOrD, irWrite, pcWrite, pcEn;
    logic        regWrite, regDst, memToReg, branch, jump, aluSrcA;
    logic [1:0]  aluSrcB, pcSrc;
    logic [3:0]  aluControl;
    logic        illegal;
    logic [3:0]  state;

    multicycle_controller dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .zero        (zero),
        .memReady    (memReady),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .iOrD        (iOrD),
        .irWrite     (irWrite),
        .pcWrite     (pcWrite),
        .pcEn        (pcEn),
        .regWrite    (regWrite),
        .regDst      (regDst),
        .memToReg    (memToReg),
        .branch      (branch),
        .jump        (jump),
        .aluSrcA     (aluSrcA),
        .aluSrcB     (aluSrcB),
        .pcSrc       (pcSrc),
        .aluControl  (aluControl),
        .illegal     (illegal),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Phase numbers equal the externally visible state codes.
    typedef enum int {
        P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3, P_MEMWB = 4,
        P_MEMWR = 5, P_EXECUTE = 6, P_ALUWB = 7, P_BRANCH = 8,
        P_ADDIEX = 9, P_ADDIWB = 10, P_JUMP = 11
    } phase_e;

    typedef enum int { C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL } iclass_e;

    logic [5:0] funct_tab [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [3:0] ctl_tab   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1100, 4'b0111};

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [24:0] exp_q [$];
    string       name_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [24:0] pack(
        input logic [3:0] st,
        input logic mr, mw, iod, irw, pcw, pce, rw, rd, m2r, br, jp, asa,
        input logic [1:0] asb, input logic [1:0] ps,
        input logic [3:0] ac, input logic ill);
        return {st, mr, mw, iod, irw, pcw, pce, rw, rd, m2r, br, jp, asa, asb, ps, ac, ill};
    endfunction

    function automatic logic [24:0] dut_word();
        return pack(state, memRead, memWrite, iOrD, irWrite, pcWrite, pcEn,
                    regWrite, regDst, memToReg, branch, jump, aluSrcA,
                    aluSrcB, pcSrc, aluControl, illegal);
    endfunction

    function automatic int funct_index(input logic [5:0] f);
        for (int i = 0; i < 6; i++) if (funct_tab[i] == f) return i;
        return -1;
    endfunction

    function automatic iclass_e classify(input logic [31:0] ins);
        logic [5:0] op;
        op = ins[31:26];
        case (op)
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000000: return (funct_index(ins[5:0]) >= 0) ? C_R : C_ILL;
            6'b000100: return C_BEQ;
            6'b001000: return C_ADDI;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    // Expected outputs for one cycle spent in a given phase.
    function automatic logic [24:0] expect_word(input phase_e ph, input logic [31:0] ins,
                                                input logic z, input logic rdy);
        logic mr, mw, iod, irw, pcw, rw, rd, m2r, br, jp, asa, ill;
        logic [1:0] asb, ps;
        logic [3:0] ac;
        int idx;
        {mr, mw, iod, irw, pcw, rw, rd, m2r, br, jp, asa, ill} = '0;
        asb = 2'b00; ps = 2'b00; ac = 4'b0000;
        case (ph)
            P_FETCH:   begin mr = 1; asb = 2'b01; ac = 4'b0010; irw = rdy; pcw = rdy; end
            P_DECODE:  begin asb = 2'b11; ac = 4'b0010; ill = (classify(ins) == C_ILL); end
            P_MEMADR:  begin asa = 1; asb = 2'b10; ac = 4'b0010; end
            P_MEMRD:   begin mr = 1; iod = 1; end
            P_MEMWB:   begin rw = 1; m2r = 1; end
            P_MEMWR:   begin mw = 1; iod = 1; end
            P_EXECUTE: begin
                asa = 1;
                idx = funct_index(ins[5:0]);
                ac  = (idx >= 0) ? ctl_tab[idx] : 4'bxxxx;
            end
            P_ALUWB:   begin rw = 1; rd = 1; end
            P_BRANCH:  begin asa = 1; ac = 4'b0110; br = 1; ps = 2'b01; end
            P_ADDIEX:  begin asa = 1; asb = 2'b10; ac = 4'b0010; end
            P_ADDIWB:  begin rw = 1; end
            P_JUMP:    begin jp = 1; pcw = 1; ps = 2'b10; end
            default:   ;
        endcase
        return pack(4'(int'(ph)), mr, mw, iod, irw, pcw, pcw | (br & z), rw, rd, m2r,
                    br, jp, asa, asb, ps, ac, ill);
    endfunction

    task automatic check(input string nm, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %07h expected %07h", nm, act, exp);
        end
    endtask

    // Monitor: one queued expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [24:0] e;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, dut_word(), e);
        end
    end

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic do_cycle(input phase_e ph, input logic rdy, input logic [31:0] ins,
                            input int zsel);
        @(posedge clk);
        #1;
        instruction = ins;
        memReady    = rdy;
        zero        = (zsel < 0) ? rbit() : zsel[0];
        exp_q.push_back(expect_word(ph, ins, zero, rdy));
        name_q.push_back($sformatf("%s@cyc%0d ins=%08h", ph.name(), cyc, ins));
    endtask

    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw, input int zsel);
        for (int i = 0; i < fw; i++) do_cycle(P_FETCH, 1'b0, ins, -1);
        do_cycle(P_FETCH, 1'b1, ins, -1);
        do_cycle(P_DECODE, rbit(), ins, -1);
        case (classify(ins))
            C_LW: begin
                do_cycle(P_MEMADR, rbit(), ins, -1);
                for (int i = 0; i < mw; i++) do_cycle(P_MEMRD, 1'b0, ins, -1);
                do_cycle(P_MEMRD, 1'b1, ins, -1);
                do_cycle(P_MEMWB, rbit(), ins, -1);
            end
            C_SW: begin
                do_cycle(P_MEMADR, rbit(), ins, -1);
                for (int i = 0; i < mw; i++) do_cycle(P_MEMWR, 1'b0, ins, -1);
                do_cycle(P_MEMWR, 1'b1, ins, -1);
            end
            C_R: begin
                do_cycle(P_EXECUTE, rbit(), ins, -1);
                do_cycle(P_ALUWB, rbit(), ins, -1);
            end
            C_BEQ:  do_cycle(P_BRANCH, rbit(), ins, zsel);
            C_ADDI: begin
                do_cycle(P_ADDIEX, rbit(), ins, -1);
                do_cycle(P_ADDIWB, rbit(), ins, -1);
            end
            C_J:    do_cycle(P_JUMP, rbit(), ins, -1);
            default: ;
        endcase
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] body;
        logic [5:0]  f;
        logic [5:0]  op;
        body = $urandom;
        case ($urandom_range(0, 7))
            0: return {6'b100011, body[25:0]};
            1: return {6'b101011, body[25:0]};
            2: return {6'b000000, body[25:6], funct_tab[$urandom_range(0, 5)]};
            3: begin
                f = body[5:0];
                if (funct_index(f) >= 0) f = 6'h00;
                return {6'b000000, body[25:6], f};
            end
            4: return {6'b000100, body[25:0]};
            5: return {6'b001000, body[25:0]};
            6: return {6'b000010, body[25:0]};
            default: begin
                op = 6'($urandom_range(0, 63));
                if (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                    op = 6'b111111;
                return {op, body[25:0]};
            end
        endcase
    endfunction

    initial begin
        logic [31:0] sw_ins;
        reset       = 1'b0;
        memReady    = 1'b0;
        zero        = 1'b0;
        instruction = 32'h0;
        #1;
        check("reset_outputs_zero", dut_word(), 25'h0);
        #11;   // t=12, between edges
        reset = 1'b1;
        #1;
        check("release_fetch_outputs", dut_word(), expect_word(P_FETCH, instruction, zero, memReady));

        // Directed instructions
        run_instr(32'h8C080004, 0, 0, -1);   // lw
        run_instr(32'h01095020, 0, 0, -1);   // add
        run_instr(32'h11090002, 0, 0, 1);    // beq taken
        run_instr(32'h11090002, 0, 0, 0);    // beq not taken
        run_instr(32'hFC000000, 0, 0, -1);   // illegal op
        run_instr(32'h0109503F, 0, 0, -1);   // R-type, unsupported funct
        run_instr(32'h8C080004, 3, 2, -1);   // fetch and load wait states
        run_instr(32'hAC090008, 1, 3, -1);   // sw with write wait states
        run_instr(32'h2108FFFF, 0, 0, -1);   // addi
        run_instr(32'h08000010, 0, 0, -1);   // j

        // Reset abandons a store stuck in MEMWR
        sw_ins = 32'hAC090008;
        do_cycle(P_FETCH, 1'b1, sw_ins, -1);
        do_cycle(P_DECODE, 1'b0, sw_ins, -1);
        do_cycle(P_MEMADR, 1'b0, sw_ins, -1);
        do_cycle(P_MEMWR, 1'b0, sw_ins, -1);
        do_cycle(P_MEMWR, 1'b0, sw_ins, -1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset_in_memwr_memWrite", {24'h0, memWrite}, 25'h0);
        check("reset_in_memwr_word", dut_word(), 25'h0);
        memReady = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("reset_held_word", dut_word(), 25'h0);
        end
        #1;
        memReady = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        check("reset_release_fetch", dut_word(), expect_word(P_FETCH, sw_ins, zero, memReady));

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            run_instr(gen_instr(), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
